// File: rtl/axis_irc_rx_gen.sv
// Oversampling serial receiver: 5-9 data bits, optional parity, 1/2 stop bits,
// 3-sample majority per bit, decoded words buffered in a FWFT FIFO on AXI4-Stream.
module axis_irc_rx_gen #(
  parameter int unsigned C_DATA_BIT = 8,
  parameter int unsigned C_OVS      = 16,
  parameter int unsigned C_FIFO_AW  = 3
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [15:0]             mod_m,
  input  logic [1:0]              parity_mode,
  input  logic                    stop2,
  input  logic                    rx,
  input  logic                    m_axis_tready,
  output logic [C_DATA_BIT-1:0]   m_axis_tdata,
  output logic [1:0]              m_axis_tuser,
  output logic                    m_axis_tvalid,
  output logic [C_FIFO_AW:0]      fifo_count,
  output logic                    busy,
  output logic                    overrun,
  input  logic                    ovr_clr
);

  localparam int unsigned CNT_W = $clog2(C_OVS);
  localparam int unsigned BIT_W = $clog2(C_DATA_BIT);
  localparam int unsigned ENT_W = C_DATA_BIT + 2;
  localparam int unsigned DEPTH = 1 << C_FIFO_AW;
  localparam int unsigned FC_W  = C_FIFO_AW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t                 state_q, state_d;
  logic                   rx_m, rx_s;
  logic [15:0]            baud_cnt;
  logic                   tick_c, start_c, last_c, maj_c, ferr_n_c, push_c;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [1:0]             smp_q, smp_d;
  logic [C_DATA_BIT-1:0]  data_q, data_d;
  logic                   perr_q, perr_d, ferr_q, ferr_d;
  logic                   stop_idx_q, stop_idx_d;
  logic [1:0]             par_mode_q, par_mode_d;
  logic                   stop2_q, stop2_d;
  logic [ENT_W-1:0]       push_word_c;

  // Two-flop synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge aclk) begin
    if (areset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  assign start_c = (state_q == S_IDLE) && !rx_s;
  // >= keeps the divider from running away if mod_m shrinks mid-count
  assign tick_c  = (mod_m <= 16'd1) || (baud_cnt >= (mod_m - 16'd1));

  always_ff @(posedge aclk) begin
    if (areset)                baud_cnt <= '0;
    else if (start_c || tick_c) baud_cnt <= '0;
    else                       baud_cnt <= baud_cnt + 16'd1;
  end

  assign last_c      = tick_c && (cnt_q == CNT_W'(C_OVS - 1));
  assign maj_c       = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
  assign ferr_n_c    = ferr_q | ~maj_c;
  assign push_word_c = {perr_q, ferr_n_c, data_q};

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      smp_q      <= '0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      stop_idx_q <= 1'b0;
      par_mode_q <= 2'b00;
      stop2_q    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      smp_q      <= smp_d;
      data_q     <= data_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      stop_idx_q <= stop_idx_d;
      par_mode_q <= par_mode_d;
      stop2_q    <= stop2_d;
      busy       <= (state_d != S_IDLE);
    end
  end

  // Next-state and frame datapath
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    smp_d      = smp_q;
    data_d     = data_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    stop_idx_d = stop_idx_q;
    par_mode_d = par_mode_q;
    stop2_d    = stop2_q;
    push_c     = 1'b0;

    if (tick_c && (state_q == S_DATA || state_q == S_PARITY || state_q == S_STOP)) begin
      if (cnt_q == CNT_W'(C_OVS - 3)) smp_d[0] = rx_s;
      if (cnt_q == CNT_W'(C_OVS - 2)) smp_d[1] = rx_s;
      cnt_d = last_c ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d    = S_START;
          cnt_d      = '0;
          par_mode_d = parity_mode;
          stop2_d    = stop2;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
        end
      end
      S_START: begin
        if (tick_c) begin
          if (cnt_q == CNT_W'(C_OVS / 2 - 1)) begin
            cnt_d   = '0;
            bit_d   = '0;
            state_d = rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DATA: begin
        if (last_c) begin
          data_d = {maj_c, data_q[C_DATA_BIT-1:1]};
          if (bit_q == BIT_W'(C_DATA_BIT - 1)) begin
            stop_idx_d = 1'b0;
            state_d    = (par_mode_q[0] ^ par_mode_q[1]) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (last_c) begin
          perr_d  = (^data_q) ^ maj_c ^ (par_mode_q == 2'b10);
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (last_c) begin
          ferr_d = ferr_n_c;
          if (stop2_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else begin
            push_c  = 1'b1;
            state_d = ferr_n_c ? S_BREAK : S_IDLE;
          end
        end
      end
      S_BREAK: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // First-word-fall-through output FIFO
  logic [ENT_W-1:0]     mem [DEPTH];
  logic [C_FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FC_W-1:0]      count_q, count_d;
  logic                 valid_q, pop_c, full_c, wr_en_c, ovr_set_c;
  logic [ENT_W-1:0]     rd_word_c;

  assign pop_c     = valid_q && m_axis_tready;
  assign full_c    = (count_q == FC_W'(DEPTH));
  assign wr_en_c   = push_c && (!full_c || pop_c);
  assign ovr_set_c = push_c && full_c && !pop_c;

  always_comb begin
    count_d = count_q;
    if (wr_en_c && !pop_c)      count_d = count_q + FC_W'(1);
    else if (!wr_en_c && pop_c) count_d = count_q - FC_W'(1);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (wr_en_c) begin
        mem[wr_ptr_q] <= push_word_c;
        wr_ptr_q      <= wr_ptr_q + C_FIFO_AW'(1);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + C_FIFO_AW'(1);
      count_q <= count_d;
      valid_q <= (count_d != '0);
      // A new overrun wins over a simultaneous clear
      if (ovr_set_c)    overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

  assign rd_word_c     = mem[rd_ptr_q];
  assign m_axis_tdata  = rd_word_c[C_DATA_BIT-1:0];
  assign m_axis_tuser  = rd_word_c[ENT_W-1:C_DATA_BIT];
  assign m_axis_tvalid = valid_q;
  assign fifo_count    = count_q;

endmodule

// File: tb/tb_axis_irc_rx_gen.sv
// Self-checking bench for axis_irc_rx_gen: drives serial frames and compares
// popped words against a frame-level reference model.
module tb_axis_irc_rx_gen;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [15:0] mod_m = 16'd4;
  logic [1:0]  parity_mode = 2'b00;
  logic        stop2 = 1'b0;
  logic        rx = 1'b1;
  logic        m_axis_tready = 1'b0;
  logic [7:0]  m_axis_tdata;
  logic [1:0]  m_axis_tuser;
  logic        m_axis_tvalid;
  logic [3:0]  fifo_count;
  logic        busy;
  logic        overrun;
  logic        ovr_clr = 1'b0;

  int checks = 0;
  int errors = 0;
  int bitlen = 64;

  axis_irc_rx_gen #(.C_DATA_BIT(8), .C_OVS(16), .C_FIFO_AW(3)) dut (
    .aclk(aclk), .areset(areset), .mod_m(mod_m), .parity_mode(parity_mode),
    .stop2(stop2), .rx(rx), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .fifo_count(fifo_count), .busy(busy),
    .overrun(overrun), .ovr_clr(ovr_clr)
  );

  always #5 aclk = ~aclk;

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Reference: word a frame should produce, from what was put on the line
  function automatic logic [9:0] model_word(input logic [7:0] d, input logic [1:0] pm,
                                            input logic pbit, input logic s2, input logic [1:0] sv);
    int ones;
    logic perr, ferr;
    ones = $countones(d) + int'(pbit);
    perr = (pm == 2'b01) ? (ones % 2 != 0) : (pm == 2'b10) ? (ones % 2 == 0) : 1'b0;
    ferr = !sv[0] || (s2 && !sv[1]);
    return {perr, ferr, d};
  endfunction

  function automatic logic good_pbit(input logic [7:0] d, input logic [1:0] pm);
    logic even_bit;
    even_bit = ($countones(d) % 2) != 0;
    return (pm == 2'b10) ? !even_bit : even_bit;
  endfunction

  task automatic do_reset();
    areset = 1'b1;
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
  endtask

  task automatic drive_bit(input logic v, input int g);
    rx = v;
    for (int i = 0; i < bitlen; i++) begin
      @(negedge aclk);
      rx = (i == g) ? ~v : v;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic pbit,
                            input logic s2, input logic [1:0] sv, input int gbit, input int goff);
    parity_mode = pm;
    stop2 = s2;
    drive_bit(1'b0, -1);
    for (int i = 0; i < 8; i++) drive_bit(d[i], (i == gbit) ? goff : -1);
    if (pm == 2'b01 || pm == 2'b10) drive_bit(pbit, -1);
    drive_bit(sv[0], -1);
    if (s2) drive_bit(sv[1], -1);
  endtask

  task automatic pop_beat(output logic [9:0] w, output logic ok);
    int n;
    n = 0;
    ok = 1'b0;
    w = '0;
    while (!m_axis_tvalid && n < 4000) begin
      @(negedge aclk);
      n++;
    end
    if (m_axis_tvalid) begin
      ok = 1'b1;
      w = {m_axis_tuser, m_axis_tdata};
      m_axis_tready = 1'b1;
      @(negedge aclk);
      m_axis_tready = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%0b exp=0", m_axis_tvalid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
    checks++; if ({m_axis_tuser, m_axis_tdata} !== 10'h0) begin errors++; $display("FAIL reset_data got=%h exp=000", {m_axis_tuser, m_axis_tdata}); end
  endtask

  task automatic test_basic();
    logic [7:0] d;
    logic [9:0] w;
    logic ok;
    int n;
    d = 8'hA5;
    mod_m = 16'd4; bitlen = 64; parity_mode = 2'b00; stop2 = 1'b0;
    drive_bit(1'b0, -1);
    for (int i = 0; i < 8; i++) drive_bit(d[i], -1);
    rx = 1'b1;
    n = 0;
    while (!m_axis_tvalid && n < 100) begin
      @(negedge aclk);
      n++;
    end
    // Stop-bit centre is 32 clocks in; allow the synchroniser and push latency
    checks++; if (n < 32 || n > 40) begin errors++; $display("FAIL basic_latency got=%0d exp=32..40", n); end
    checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL basic_count got=%0d exp=1", fifo_count); end
    repeat (bitlen) @(negedge aclk);
    pop_beat(w, ok);
    checks++; if (!ok || w !== {2'b00, d}) begin errors++; $display("FAIL basic_word got=%h exp=%h ok=%0b", w, {2'b00, d}, ok); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_glitch();
    logic [9:0] w;
    logic ok;
    int gb, go;
    rx = 1'b0;
    repeat (10) @(negedge aclk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start got=%0b exp=1", busy); end
    repeat (10) @(negedge aclk);
    rx = 1'b1;
    repeat (60) @(negedge aclk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_false_start got=%0b exp=0", busy); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL glitch_no_word got=%0d exp=0", fifo_count); end
    gb = int'($urandom_range(0, 7));
    go = int'($urandom_range(0, 62));
    send_frame(8'h3C, 2'b00, 1'b0, 1'b0, 2'b11, gb, go);
    repeat (8) @(negedge aclk);
    checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL glitch_count got=%0d exp=1", fifo_count); end
    pop_beat(w, ok);
    checks++; if (!ok || w !== 10'h03C) begin errors++; $display("FAIL glitch_word bit=%0d off=%0d got=%h exp=03c", gb, go, w); end
  endtask

  task automatic test_parity();
    logic [9:0] exp_q[$];
    logic [9:0] w;
    logic ok;
    logic [1:0] pm [3];
    logic pb [3];
    pm[0] = 2'b01; pb[0] = 1'b0;
    pm[1] = 2'b01; pb[1] = 1'b1;
    pm[2] = 2'b10; pb[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_frame(8'h3C, pm[i], pb[i], 1'b0, 2'b11, -1, 0);
      exp_q.push_back(model_word(8'h3C, pm[i], pb[i], 1'b0, 2'b11));
    end
    repeat (8) @(negedge aclk);
    checks++; if (fifo_count !== 4'd3) begin errors++; $display("FAIL parity_count got=%0d exp=3", fifo_count); end
    for (int i = 0; i < 3; i++) begin
      pop_beat(w, ok);
      checks++; if (!ok || w !== exp_q[i]) begin errors++; $display("FAIL parity_word%0d got=%h exp=%h ok=%0b", i, w, exp_q[i], ok); end
    end
  endtask

  task automatic test_break();
    logic [7:0] d;
    logic [9:0] w;
    logic ok;
    d = 8'($urandom);
    send_frame(d, 2'b00, 1'b0, 1'b0, 2'b00, -1, 0);
    repeat (10 * bitlen) @(negedge aclk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL break_held got=%0b exp=1", busy); end
    checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL break_one_word got=%0d exp=1", fifo_count); end
    rx = 1'b1;
    repeat (10) @(negedge aclk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_release got=%0b exp=0", busy); end
    pop_beat(w, ok);
    checks++; if (!ok || w !== model_word(d, 2'b00, 1'b0, 1'b0, 2'b00)) begin errors++; $display("FAIL break_word got=%h exp=%h", w, model_word(d, 2'b00, 1'b0, 1'b0, 2'b00)); end
    repeat (bitlen) @(negedge aclk);
    send_frame(8'h55, 2'b00, 1'b0, 1'b0, 2'b11, -1, 0);
    pop_beat(w, ok);
    checks++; if (!ok || w !== 10'h055) begin errors++; $display("FAIL break_next got=%h exp=055", w); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL break_empty got=%0d exp=0", fifo_count); end
  endtask

  task automatic test_overrun();
    logic [9:0] exp_q[$];
    logic [7:0] d;
    logic [9:0] w;
    logic ok;
    m_axis_tready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      d = 8'($urandom);
      send_frame(d, 2'b00, 1'b0, 1'b0, 2'b11, -1, 0);
      if (i < 8) exp_q.push_back(model_word(d, 2'b00, 1'b0, 1'b0, 2'b11));
    end
    repeat (8) @(negedge aclk);
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL ovr_count got=%0d exp=8", fifo_count); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got=%0b exp=1", overrun); end
    checks++; if ({m_axis_tuser, m_axis_tdata} !== exp_q[0]) begin errors++; $display("FAIL ovr_head_stable got=%h exp=%h", {m_axis_tuser, m_axis_tdata}, exp_q[0]); end
    ovr_clr = 1'b1;
    @(negedge aclk);
    ovr_clr = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got=%0b exp=0", overrun); end
    for (int i = 0; i < 8; i++) begin
      pop_beat(w, ok);
      checks++; if (!ok || w !== exp_q[i]) begin errors++; $display("FAIL ovr_word%0d got=%h exp=%h ok=%0b", i, w, exp_q[i], ok); end
    end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL ovr_drained got=%0d exp=0", fifo_count); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp_q[$];
    logic [7:0] d;
    logic [1:0] pm, sv;
    logic pb, s2;
    logic [9:0] w;
    logic ok;
    logic [15:0] mods [3];
    mods[0] = 16'd2; mods[1] = 16'd3; mods[2] = 16'd4;
    for (int r = 0; r < 3; r++) begin
      mod_m = mods[r];
      bitlen = int'(mods[r]) * 16;
      for (int f = 0; f < 6; f++) begin
        d  = 8'($urandom);
        pm = 2'($urandom);
        s2 = 1'($urandom);
        pb = good_pbit(d, pm) ^ ($urandom_range(0, 3) == 0);
        sv = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b11;
        send_frame(d, pm, pb, s2, sv, -1, 0);
        exp_q.push_back(model_word(d, pm, pb, s2, sv));
        // A framing error parks the receiver until the line goes idle again
        if (!sv[0] || (s2 && !sv[1])) drive_bit(1'b1, -1);
      end
      for (int i = 0; i < 6; i++) begin
        pop_beat(w, ok);
        checks++; if (!ok || w !== exp_q[i]) begin errors++; $display("FAIL b2b_r%0d_w%0d got=%h exp=%h ok=%0b", r, i, w, exp_q[i], ok); end
      end
      exp_q.delete();
      repeat (bitlen) @(negedge aclk);
    end
    mod_m = 16'd4;
    bitlen = 64;
  endtask

  task automatic test_reset_cfg();
    logic [7:0] d;
    logic [9:0] w;
    logic ok;
    send_frame(8'h81, 2'b00, 1'b0, 1'b0, 2'b11, -1, 0);
    repeat (8) @(negedge aclk);
    checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL rcfg_pre_count got=%0d exp=1", fifo_count); end
    drive_bit(1'b0, -1);
    drive_bit(1'b1, -1);
    drive_bit(1'b0, -1);
    rx = 1'b0;
    repeat (bitlen / 2) @(negedge aclk);
    areset = 1'b1;
    rx = 1'b1;
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rcfg_tvalid got=%0b exp=0", m_axis_tvalid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rcfg_busy got=%0b exp=0", busy); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL rcfg_count got=%0d exp=0", fifo_count); end
    repeat (2 * bitlen) @(negedge aclk);
    d = 8'($urandom);
    send_frame(d, 2'b00, 1'b0, 1'b1, 2'b01, -1, 0);
    drive_bit(1'b1, -1);
    pop_beat(w, ok);
    checks++; if (!ok || w !== model_word(d, 2'b00, 1'b0, 1'b1, 2'b01)) begin errors++; $display("FAIL rcfg_stop2_word got=%h exp=%h", w, model_word(d, 2'b00, 1'b0, 1'b1, 2'b01)); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL rcfg_empty got=%0d exp=0", fifo_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_parity();
    test_break();
    test_overrun();
    test_back_to_back();
    test_reset_cfg();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
